// File: rtl/pbit_local_field.sv
// Local field z = bias + sum_j W[j]*m[j] for one p-bit, one neighbour per cycle, Q(INT_SIZE).(FLOAT_SIZE).
// Define PBIT_LOCAL_FIELD_SAT_EN to saturate z instead of wrapping it.
module pbit_local_field #(
    parameter int N_NEIGH    = 4,
    parameter int INT_SIZE   = 8,
    parameter int FLOAT_SIZE = 24,
    parameter int ADDR_W     = 2
) (
    input  logic                           CLK,
    input  logic                           RST,
    input  logic                           start,
    input  logic [N_NEIGH-1:0]             m_vec,
    input  logic [INT_SIZE+FLOAT_SIZE-1:0] bias,
    input  logic                           w_we,
    input  logic [ADDR_W-1:0]              w_addr,
    input  logic [INT_SIZE+FLOAT_SIZE-1:0] w_data,
    output logic [INT_SIZE+FLOAT_SIZE-1:0] z,
    output logic                           z_valid,
    output logic                           busy
);

    localparam int Z_W   = INT_SIZE + FLOAT_SIZE;
    localparam int ACC_W = Z_W + $clog2(N_NEIGH + 1) + 1;
    localparam logic [ADDR_W:0]   N_NEIGH_W = (ADDR_W + 1)'(N_NEIGH);
    localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(N_NEIGH - 1);

    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    state_t                   state;
    state_t                   state_next;
    logic [N_NEIGH-1:0]       m_lat;
    logic [ADDR_W-1:0]        idx;
    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W-1:0]  w_ext;
    logic [Z_W-1:0]           z_narrow;
    logic [Z_W-1:0]           weights [N_NEIGH];

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = ACCUM;
            ACCUM:   if (idx == LAST_IDX) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
    end

    // Writes land at the clock edge, so a same-cycle read of that entry still sees the old weight.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < N_NEIGH; i++) begin
                weights[i] <= '0;
            end
        end else if (w_we && ({1'b0, w_addr} < N_NEIGH_W)) begin
            weights[w_addr] <= w_data;
        end
    end

    assign w_ext = {{(ACC_W - Z_W){weights[idx][Z_W-1]}}, weights[idx]};

    always_ff @(posedge CLK) begin
        if (RST) begin
            acc     <= '0;
            idx     <= '0;
            m_lat   <= '0;
            z       <= '0;
            z_valid <= 1'b0;
        end else begin
            z_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        m_lat <= m_vec;
                        acc   <= {{(ACC_W - Z_W){bias[Z_W-1]}}, bias};
                        idx   <= '0;
                    end
                end
                ACCUM: begin
                    acc <= m_lat[idx] ? (acc + w_ext) : (acc - w_ext);
                    idx <= idx + ADDR_W'(1);
                end
                DONE: begin
                    z       <= z_narrow;
                    z_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef PBIT_LOCAL_FIELD_SAT_EN
    // The value fits in Z_W bits only when all bits from the Z_W sign position upward agree.
    logic [ACC_W-Z_W:0] acc_top;
    assign acc_top = acc[ACC_W-1:Z_W-1];

    always_comb begin
        z_narrow = acc[Z_W-1:0];
        if (!((acc_top == '0) || (acc_top == '1))) begin
            z_narrow = acc[ACC_W-1] ? {1'b1, {(Z_W-1){1'b0}}} : {1'b0, {(Z_W-1){1'b1}}};
        end
    end
`else
    logic unused_acc_hi;
    assign z_narrow      = acc[Z_W-1:0];
    assign unused_acc_hi = ^acc[ACC_W-1:Z_W];
`endif

endmodule

// File: tb/tb_pbit_local_field.sv
// Scoreboard bench for pbit_local_field: expected z values are queued at start and popped on z_valid.
module tb_pbit_local_field;

    typedef struct {
        logic [31:0] z;
        int          cyc;
    } exp_t;

    logic        CLK = 1'b0;
    logic        RST;
    logic        start;
    logic [3:0]  m_vec;
    logic [31:0] bias;
    logic        w_we;
    logic [1:0]  w_addr;
    logic [31:0] w_data;
    logic [31:0] z;
    logic        z_valid;
    logic        busy;

    exp_t        sbQ[$];
    logic [31:0] tbW[4];
    logic [31:0] lastExp;
    int          total = 0;
    int          bad = 0;
    int          cycleCount = 0;
    int          validCount = 0;

    always #5 CLK = ~CLK;

    pbit_local_field dut (
        .CLK     (CLK),
        .RST     (RST),
        .start   (start),
        .m_vec   (m_vec),
        .bias    (bias),
        .w_we    (w_we),
        .w_addr  (w_addr),
        .w_data  (w_data),
        .z       (z),
        .z_valid (z_valid),
        .busy    (busy)
    );

    always @(posedge CLK) cycleCount <= cycleCount + 1;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Reference sum in 64-bit integer arithmetic, then narrowed to 32 bits.
    function automatic logic [31:0] modelZ(input logic [3:0] m, input logic [31:0] b);
        longint acc;
        acc = longint'($signed(b));
        for (int i = 0; i < 4; i++) begin
            if (m[i]) acc = acc + longint'($signed(tbW[i]));
            else      acc = acc - longint'($signed(tbW[i]));
        end
`ifdef PBIT_LOCAL_FIELD_SAT_EN
        if (acc > 64'sd2147483647)  return 32'h7FFFFFFF;
        if (acc < -64'sd2147483648) return 32'h80000000;
`endif
        return acc[31:0];
    endfunction

    always @(negedge CLK) begin
        if (z_valid === 1'b1) begin
            exp_t e;
            validCount++;
            total++;
            assert (sbQ.size() != 0) else begin
                bad++;
                $error("[TB] FAIL unexpected_valid observed=1 expected=0");
            end
            if (sbQ.size() != 0) begin
                e = sbQ.pop_front();
                checkOutput("z_value", z, e.z);
                checkOutput("z_latency", 32'(cycleCount), 32'(e.cyc));
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic writeWeight(input logic [1:0] addr, input logic [31:0] data);
        w_we   = 1'b1;
        w_addr = addr;
        w_data = data;
        tick();
        w_we   = 1'b0;
        tbW[addr] = data;
    endtask

    task automatic pushExpected(input logic [3:0] m, input logic [31:0] b);
        exp_t e;
        e.z     = modelZ(m, b);
        e.cyc   = cycleCount + 6;
        lastExp = e.z;
        sbQ.push_back(e);
    endtask

    // Start from IDLE, then scramble the inputs so a design that fails to latch them is caught.
    task automatic applyStimulus(input logic [3:0] m, input logic [31:0] b);
        m_vec = m;
        bias  = b;
        start = 1'b1;
        pushExpected(m, b);
        tick();
        start = 1'b0;
        m_vec = ~m;
        bias  = 32'h12345678;
        checkOutput("busy_accum", {31'b0, busy}, 32'd1);
    endtask

    task automatic waitDone();
        int n = 0;
        while (sbQ.size() != 0 && n < 20) begin
            tick();
            n++;
        end
        total++;
        assert (sbQ.size() == 0) else begin
            bad++;
            $error("[TB] FAIL result_timeout observed=%0d expected=0", sbQ.size());
            sbQ.delete();
        end
    endtask

    task automatic loadBaseWeights();
        writeWeight(2'd0, 32'h01000000);
        writeWeight(2'd1, 32'hFF800000);
        writeWeight(2'd2, 32'h00400000);
        writeWeight(2'd3, 32'h02000000);
    endtask

    initial begin
        int v0;
        RST    = 1'b1;
        start  = 1'b0;
        m_vec  = 4'b0;
        bias   = 32'b0;
        w_we   = 1'b0;
        w_addr = 2'b0;
        w_data = 32'b0;
        for (int i = 0; i < 4; i++) tbW[i] = 32'b0;
        repeat (5) tick();
        RST = 1'b0;
        checkOutput("reset_z", z, 32'h00000000);
        checkOutput("reset_valid", {31'b0, z_valid}, 32'd0);
        checkOutput("reset_busy", {31'b0, busy}, 32'd0);

        applyStimulus(4'b1111, 32'h00000000);
        waitDone();

        loadBaseWeights();
        applyStimulus(4'b1111, 32'h00000000);
        waitDone();
        checkOutput("const_all_plus", z, 32'h02C00000);
        applyStimulus(4'b0000, 32'h00000000);
        waitDone();
        checkOutput("const_all_minus", z, 32'hFD400000);
        applyStimulus(4'b0101, 32'h00000000);
        waitDone();
        checkOutput("const_0101", z, 32'hFFC00000);
        applyStimulus(4'b1111, 32'h00800000);
        waitDone();
        repeat (3) tick();
        checkOutput("z_hold", z, lastExp);
        checkOutput("idle_busy", {31'b0, busy}, 32'd0);

        // Twelve consecutive start pulses: only the ones landing in IDLE are accepted.
        v0    = validCount;
        m_vec = 4'b1111;
        bias  = 32'h00800000;
        for (int i = 0; i < 12; i++) begin
            start = 1'b1;
            if (i == 0 || i == 6) pushExpected(4'b1111, 32'h00800000);
            tick();
        end
        start = 1'b0;
        waitDone();
        repeat (4) tick();
        checkOutput("storm_pulses", 32'(validCount - v0), 32'd2);

        // Overwriting W0 while it is being read: the old value is still used this time.
        m_vec = 4'b1111;
        bias  = 32'h00000000;
        start = 1'b1;
        pushExpected(4'b1111, 32'h00000000);
        tick();
        start = 1'b0;
        writeWeight(2'd0, 32'h00000000);
        waitDone();
        applyStimulus(4'b0001, 32'h00000000);
        waitDone();
        writeWeight(2'd0, 32'h01000000);

        // W3 rewritten while idx=1, before it is reached: the new value is used.
        m_vec = 4'b1111;
        bias  = 32'h00000000;
        tbW[3] = 32'h00000000;
        start = 1'b1;
        pushExpected(4'b1111, 32'h00000000);
        tbW[3] = 32'h02000000;
        tick();
        start = 1'b0;
        tick();
        writeWeight(2'd3, 32'h00000000);
        waitDone();
        checkOutput("const_w3_update", z, 32'h00C00000);

        for (int i = 0; i < 4; i++) writeWeight(2'(i), 32'h7F000000);
        applyStimulus(4'b1111, 32'h7F000000);
        waitDone();
        applyStimulus(4'b0000, 32'h81000000);
        waitDone();

        // Reset two cycles into a computation: no result may appear and weights are cleared.
        m_vec = 4'b1111;
        bias  = 32'h00000000;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        RST = 1'b1;
        tick();
        RST = 1'b0;
        for (int i = 0; i < 4; i++) tbW[i] = 32'b0;
        checkOutput("abort_z", z, 32'h00000000);
        checkOutput("abort_busy", {31'b0, busy}, 32'd0);
        repeat (8) tick();
        applyStimulus(4'b1111, 32'h00800000);
        waitDone();
        repeat (2) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
